spi_output: RTL and testbench

- SPI slave transmitter: drives MISO back to the external SPI master.
- Pairs with the existing slave receiver on the same sck/cs pins, in the same SPI mode (CPOL=0, CPHA=1).
- The slave drives a new bit on each sck rising edge; the master samples on the falling edge.
- Words come from fabric logic through a one-word holding buffer with a valid/ready handshake. An empty buffer at word start sends a fill pattern and flags underrun.

---
 rtl/spi_output_pkg.sv | 16 +
 rtl/spi_output_sync_edge.sv | 31 +++
 rtl/spi_output.sv | 109 ++++++++++
 tb/tb_spi_output.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_output_pkg.sv
// Constants shared by the SPI slave transmitter and receiver.
package spi_output_pkg;

    localparam int SPI_LENGTH_DEFAULT = 8;

    // Mode 1: sck idles low, slave drives on the rising edge, master samples on the falling edge.
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b1;

    localparam logic [31:0] SPI_FILL_DEFAULT = 32'hFFFF_FFFF;

    function automatic int spi_cnt_width(input int length);
        return $clog2(length + 1);
    endfunction

endpackage

// File: rtl/spi_output_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with rising/falling edge pulses.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_output.sv
// SPI mode-1 slave transmitter: one-word holding buffer feeding a MSB-first shifter on miso.
module spi_output
    import spi_output_pkg::*;
#(
    parameter int                LENGTH = SPI_LENGTH_DEFAULT,
    parameter logic [LENGTH-1:0] FILL   = SPI_FILL_DEFAULT[LENGTH-1:0]
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              cs,
    output logic              miso,
    output logic              miso_oe,
    input  logic [LENGTH-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              underrun,
    output logic              word_done
);

    localparam int CW = spi_cnt_width(LENGTH);

    logic              sck_sync, sck_rise, sck_fall;
    logic              cs_sync, cs_rise, cs_fall;
    logic [LENGTH-1:0] hold_data;
    logic              full;
    logic [LENGTH-1:0] shreg;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_base;
    logic [CW-1:0]     cnt_inc;
    logic [LENGTH-1:0] word;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sck),
        .sync (sck_sync),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (cs),
        .sync (cs_sync),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // A cs fall coinciding with an sck rise must see a zeroed counter in the same clk.
    always_comb begin
        cnt_base = cs_fall ? '0 : cnt;
        cnt_inc  = cnt_base + CW'(1);
        word     = full ? hold_data : FILL;
    end

    assign tx_ready = ~full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            hold_data <= '0;
            full      <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            underrun  <= 1'b0;
            word_done <= 1'b0;
        end else begin
            underrun  <= 1'b0;
            word_done <= 1'b0;

            if (tx_valid && !full) begin
                hold_data <= tx_data;
                full      <= 1'b1;
            end

            if (cs_rise) begin
                miso_oe <= 1'b0;
                cnt     <= '0;
                miso    <= 1'b0;
            end else begin
                if (cs_fall) begin
                    miso_oe <= 1'b1;
                    cnt     <= '0;
                end
                if (sck_rise && !cs_sync) begin
                    if (cnt_base == '0) begin
                        miso  <= word[LENGTH-1];
                        shreg <= word << 1;
                        if (full) full <= 1'b0;
                        else      underrun <= 1'b1;
                    end else begin
                        miso  <= shreg[LENGTH-1];
                        shreg <= shreg << 1;
                    end
                    if (cnt_inc == CW'(LENGTH)) begin
                        cnt       <= '0;
                        word_done <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_output.sv
// Bench for spi_output: an SPI master model feeds a bit monitor that scores received words.
module tb_spi_output;

    localparam int LEN = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sck = 1'b0;
    logic           cs = 1'b1;
    logic           miso, miso_oe;
    logic [LEN-1:0] tx_data = '0;
    logic           tx_valid = 1'b0;
    logic           tx_ready, underrun, word_done;

    int checks = 0;
    int errors = 0;

    logic [LEN-1:0] exp_q[$];
    logic [LEN-1:0] rx_word = '0;
    int             rx_n = 0;
    int             wd_cnt = 0;
    int             ur_cnt = 0;
    int             ur_at_rise = -1;
    int             rise_cnt = 0;

    spi_output #(.LENGTH(LEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sck      (sck),
        .cs       (cs),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .underrun (underrun),
        .word_done(word_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: master samples on sck fall; each completed word is scored against the queue.
    always @(negedge sck) begin
        if (!cs) begin
            rx_word = {rx_word[LEN-2:0], miso};
            rx_n++;
            if (rx_n == LEN) begin
                rx_n = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_word: got 0x%0h with no word expected", rx_word);
                end else begin
                    check("rx_word", 32'(rx_word), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    always @(posedge cs) rx_n = 0;

    always @(posedge sck) if (!cs) rise_cnt++;

    always @(negedge clk) begin
        if (word_done) wd_cnt++;
        if (underrun) begin
            ur_cnt++;
            ur_at_rise = rise_cnt;
        end
    end

    task automatic load_word(input logic [LEN-1:0] d);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL load_wait: tx_ready stuck at 0 expected 1");
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic sck_bits(input int n);
        for (int i = 0; i < n; i++) begin
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
        rise_cnt = 0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic clear_counts();
        wd_cnt = 0;
        ur_cnt = 0;
        ur_at_rise = -1;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(miso), 0);
        check("rst_oe", 32'(miso_oe), 0);
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_word_done", 32'(word_done), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single word 0xA5
        clear_counts();
        load_word(8'hA5);
        check("a5_ready_full", 32'(tx_ready), 0);
        exp_q.push_back(8'hA5);
        cs_low();
        check("a5_oe", 32'(miso_oe), 1);
        sck = 1'b1;
        repeat (4) @(negedge clk);
        check("a5_ready_after_rise", 32'(tx_ready), 1);
        sck = 1'b0;
        repeat (4) @(negedge clk);
        sck_bits(7);
        check("a5_word_done", 32'(wd_cnt), 1);
        check("a5_underrun", 32'(ur_cnt), 0);
        cs_high();

        // Back-to-back 0x3C, 0xC3
        clear_counts();
        load_word(8'h3C);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        cs_low();
        fork
            sck_bits(16);
            begin
                int n = 0;
                while (!tx_ready && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("b2b_ready_rise", 32'(tx_ready), 1);
                load_word(8'hC3);
            end
        join
        check("b2b_word_done", 32'(wd_cnt), 2);
        check("b2b_underrun", 32'(ur_cnt), 0);
        cs_high();

        // Underrun
        clear_counts();
        exp_q.push_back(8'hFF);
        cs_low();
        sck_bits(8);
        check("ur_count", 32'(ur_cnt), 1);
        check("ur_first_rise", 32'(ur_at_rise), 1);
        check("ur_word_done", 32'(wd_cnt), 1);
        cs_high();

        // Abort mid-word
        clear_counts();
        load_word(8'h81);
        cs_low();
        sck_bits(3);
        @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
        check("abort_oe_1clk", 32'(miso_oe), 1);
        @(negedge clk);
        check("abort_oe_2clk", 32'(miso_oe), 1);
        @(negedge clk);
        check("abort_oe_3clk", 32'(miso_oe), 0);
        check("abort_miso", 32'(miso), 0);
        repeat (4) @(negedge clk);
        check("abort_word_done", 32'(wd_cnt), 0);
        check("abort_ready", 32'(tx_ready), 1);
        load_word(8'h55);
        exp_q.push_back(8'h55);
        cs_low();
        sck_bits(8);
        check("abort_next_wd", 32'(wd_cnt), 1);
        check("abort_next_ur", 32'(ur_cnt), 0);
        cs_high();

        // Async reset during bit 4, with another word waiting in the buffer
        clear_counts();
        load_word(8'h99);
        cs_low();
        sck_bits(4);
        load_word(8'h77);
        check("rstmid_ready", 32'(tx_ready), 0);
        check("rstmid_miso_bit4", 32'(miso), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_miso", 32'(miso), 0);
        check("rstmid_oe", 32'(miso_oe), 0);
        check("rstmid_ready_rst", 32'(tx_ready), 1);
        check("rstmid_ur", 32'(underrun), 0);
        check("rstmid_wd", 32'(word_done), 0);
        cs = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rstmid_dropped", 32'(tx_ready), 1);
        check("rstmid_no_wd", 32'(wd_cnt), 0);
        exp_q.push_back(8'hFF);
        cs_low();
        sck_bits(8);
        check("rstmid_fill_ur", 32'(ur_cnt), 1);
        cs_high();

        // Idle sck with cs high
        clear_counts();
        load_word(8'h12);
        for (int i = 0; i < 10; i++) begin
            sck_bits(1);
            if (miso_oe !== 1'b0) check("idle_oe", 32'(miso_oe), 0);
        end
        check("idle_oe_end", 32'(miso_oe), 0);
        check("idle_full", 32'(tx_ready), 0);
        check("idle_wd", 32'(wd_cnt), 0);
        exp_q.push_back(8'h12);
        cs_low();
        sck_bits(8);
        check("idle_next_ur", 32'(ur_cnt), 0);
        check("idle_next_wd", 32'(wd_cnt), 1);
        cs_high();

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
